// File: rtl/imem_arbiter_pkg.sv
// Shared types and defaults for the instruction-memory arbiter.
// word_idx() strips the byte offset so both requesters map onto memory words.
package imem_pkg;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 1024;

  function automatic logic [DEF_ADDR_W-3:0] word_idx(input logic [DEF_ADDR_W-1:0] addr);
    return addr[DEF_ADDR_W-1:2];
  endfunction

endpackage

// File: rtl/imem_arbiter_if.sv
// Bundle of fetch, loader and memory-array signals seen by the arbiter.
// slave = arbiter side, master = requesters plus memory array; IMEM_ARB_ERR_EN adds error flags.
interface imem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MEM_AW = 10
);
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_gnt;
  logic              fetch_rvalid;
  logic [DATA_W-1:0] fetch_rdata;
  logic              load_req;
  logic              load_we;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_wdata;
  logic              load_done;
  logic              load_gnt;
  logic              load_rvalid;
  logic [DATA_W-1:0] load_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              run;
`ifdef IMEM_ARB_ERR_EN
  logic              fetch_err;
  logic              load_err;
`endif

  modport slave (
`ifdef IMEM_ARB_ERR_EN
    output fetch_err, load_err,
`endif
    input  fetch_req, fetch_addr, load_req, load_we, load_addr, load_wdata, load_done, mem_rdata,
    output fetch_gnt, fetch_rvalid, fetch_rdata, load_gnt, load_rvalid, load_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, run
  );

  modport master (
`ifdef IMEM_ARB_ERR_EN
    input  fetch_err, load_err,
`endif
    output fetch_req, fetch_addr, load_req, load_we, load_addr, load_wdata, load_done, mem_rdata,
    input  fetch_gnt, fetch_rvalid, fetch_rdata, load_gnt, load_rvalid, load_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, run
  );

endinterface

// File: rtl/imem_arbiter_resp_reg.sv
// Registered read-response stage: steers one read result per cycle to its owner (1 = loader).
// One-cycle latency, no backpressure; rdata holds between pulses. IMEM_ARB_ERR_EN adds err flags.
module imem_resp_reg #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_vld,
  input  logic              owner,
  input  logic [DATA_W-1:0] rd_dat,
  output logic              fetch_rvalid,
  output logic [DATA_W-1:0] fetch_rdata,
  output logic              load_rvalid,
  output logic [DATA_W-1:0] load_rdata
`ifdef IMEM_ARB_ERR_EN
  ,
  input  logic              err_vld,
  output logic              fetch_err,
  output logic              load_err
`endif
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_rvalid <= 1'b0;
      fetch_rdata  <= '0;
      load_rvalid  <= 1'b0;
      load_rdata   <= '0;
    end else begin
      fetch_rvalid <= rd_vld & ~owner;
      load_rvalid  <= rd_vld & owner;
      if (rd_vld && !owner) fetch_rdata <= rd_dat;
      if (rd_vld && owner)  load_rdata  <= rd_dat;
    end
  end

`ifdef IMEM_ARB_ERR_EN
  // err_vld covers loader writes too, so load_err can pulse without load_rvalid
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_err <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      fetch_err <= err_vld & ~owner;
      load_err  <= err_vld & owner;
    end
  end
`endif

endmodule

// File: rtl/imem_arbiter.sv
// Single-port instruction-memory arbiter: BOOT serves only the loader, RUN gives fetch priority with a starvation guard.
// Grants are same-cycle combinational, read data one cycle later; optional error flags under IMEM_ARB_ERR_EN.
module imem_arbiter
  import imem_pkg::*;
#(
  parameter int ADDR_W           = DEF_ADDR_W,
  parameter int DATA_W           = DEF_DATA_W,
  parameter int DEPTH            = DEF_DEPTH,
  parameter int FETCH_STREAK_MAX = 8
) (
  input logic           clk,
  input logic           rst,
  imem_arbiter_if.slave bus
);

  localparam int MEM_AW = $clog2(DEPTH);
  localparam int IDX_W  = ADDR_W - 2;
  localparam int SW     = $clog2(FETCH_STREAK_MAX + 1);
  localparam logic [IDX_W-1:0] DEPTH_IDX  = IDX_W'(DEPTH);
  localparam logic [SW-1:0]    STREAK_MAX = SW'(FETCH_STREAK_MAX);

  state_t            state_q, state_d;
  logic [SW-1:0]     streak_q, streak_d;
  logic              fgnt, lgnt, any_gnt, in_range;
  logic [IDX_W-1:0]  f_idx, l_idx, sel_idx;
  logic [DATA_W-1:0] rd_dat;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= BOOT;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
    end
  end

  // Grants are gated by rst so nothing is accepted while reset is held
  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    fgnt     = 1'b0;
    lgnt     = 1'b0;
    case (state_q)
      BOOT: begin
        lgnt = bus.load_req & rst;
        if (bus.load_done) state_d = RUN;
      end
      RUN: begin
        if (bus.fetch_req && bus.load_req) begin
          if (streak_q == STREAK_MAX) lgnt = rst;
          else                        fgnt = rst;
        end else begin
          fgnt = bus.fetch_req & rst;
          lgnt = bus.load_req & rst;
        end
      end
      default: state_d = BOOT;
    endcase
    if (lgnt || !bus.load_req)             streak_d = '0;
    else if (fgnt && streak_q != STREAK_MAX) streak_d = streak_q + 1'b1;
  end

  assign f_idx    = IDX_W'(word_idx(DEF_ADDR_W'(bus.fetch_addr)));
  assign l_idx    = IDX_W'(word_idx(DEF_ADDR_W'(bus.load_addr)));
  assign sel_idx  = lgnt ? l_idx : f_idx;
  assign any_gnt  = fgnt | lgnt;
  assign in_range = sel_idx < DEPTH_IDX;

  assign bus.fetch_gnt = fgnt;
  assign bus.load_gnt  = lgnt;
  assign bus.run       = (state_q == RUN);
  assign bus.mem_en    = any_gnt & in_range;
  assign bus.mem_we    = lgnt & bus.load_we & in_range;
  assign bus.mem_addr  = any_gnt ? sel_idx[MEM_AW-1:0] : '0;
  assign bus.mem_wdata = lgnt ? bus.load_wdata : '0;

  // Out-of-range reads return zero rather than whatever the array drives
  assign rd_dat = in_range ? bus.mem_rdata : '0;

`ifdef IMEM_ARB_ERR_EN
  logic [1:0] sel_lo;
  logic       err_vld;
  assign sel_lo  = lgnt ? bus.load_addr[1:0] : bus.fetch_addr[1:0];
  assign err_vld = any_gnt & ((sel_lo != 2'b00) | ~in_range);
`endif

  imem_resp_reg #(.DATA_W(DATA_W)) u_resp (
    .clk          (clk),
    .rst          (rst),
    .rd_vld       (fgnt | (lgnt & ~bus.load_we)),
    .owner        (lgnt),
    .rd_dat       (rd_dat),
    .fetch_rvalid (bus.fetch_rvalid),
    .fetch_rdata  (bus.fetch_rdata),
    .load_rvalid  (bus.load_rvalid),
    .load_rdata   (bus.load_rdata)
`ifdef IMEM_ARB_ERR_EN
    ,
    .err_vld      (err_vld),
    .fetch_err    (bus.fetch_err),
    .load_err     (bus.load_err)
`endif
  );

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: vector table plus streak, reset and boot sequences.
module tb_imem_arbiter;
  localparam logic [31:0] WA = 32'h0064A423;
  localparam logic [31:0] WB = 32'h00B62423;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] mem [1024];

  always #5 clk = ~clk;

  imem_arbiter_if #(.ADDR_W(32), .DATA_W(32), .MEM_AW(10)) bus ();

  imem_arbiter #(.ADDR_W(32), .DATA_W(32), .DEPTH(1024), .FETCH_STREAK_MAX(8)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  assign bus.mem_rdata = mem[bus.mem_addr];
  always @(posedge clk) if (bus.mem_en && bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;

  typedef struct {
    logic fr; logic [31:0] fa;
    logic lr; logic lw; logic [31:0] la; logic [31:0] lwd; logic ld;
    logic e_fg; logic e_lg; logic e_en; logic e_we; logic [9:0] e_addr; logic [31:0] e_wd;
    logic e_fv; logic e_lv; logic [31:0] e_frd; logic [31:0] e_lrd;
    logic e_run; logic e_ferr; logic e_lerr;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic fr, input logic [31:0] fa, input logic lr, input logic lw,
                       input logic [31:0] la, input logic [31:0] lwd, input logic ld);
    bus.fetch_req  = fr;
    bus.fetch_addr = fa;
    bus.load_req   = lr;
    bus.load_we    = lw;
    bus.load_addr  = la;
    bus.load_wdata = lwd;
    bus.load_done  = ld;
  endtask

  initial begin
    //         fr fa     lr lw la        lwd           ld  fg lg en we addr wd            fv lv frd lrd  run ferr lerr
    vecs[0]  = '{0, 0,     0, 0, 0,        0,            0,  0, 0, 0, 0, 0, 0,            0, 0, 0,  0,   0, 0, 0};
    vecs[1]  = '{1, 0,     1, 1, 0,        WA,           0,  0, 1, 1, 1, 0, WA,           0, 0, 0,  0,   0, 0, 0};
    vecs[2]  = '{1, 0,     1, 1, 4,        WB,           0,  0, 1, 1, 1, 1, WB,           0, 0, 0,  0,   0, 0, 0};
    vecs[3]  = '{1, 0,     1, 0, 0,        0,            0,  0, 1, 1, 0, 0, 0,            0, 0, 0,  0,   0, 0, 0};
    vecs[4]  = '{1, 0,     1, 0, 4,        0,            1,  0, 1, 1, 0, 1, 0,            0, 1, 0,  WA,  0, 0, 0};
    vecs[5]  = '{1, 4,     0, 0, 0,        0,            0,  1, 0, 1, 0, 1, 0,            0, 1, 0,  WB,  1, 0, 0};
    vecs[6]  = '{0, 0,     0, 0, 0,        0,            0,  0, 0, 0, 0, 0, 0,            1, 0, WB, WB,  1, 0, 0};
    vecs[7]  = '{0, 0,     1, 0, 32'h1000, 0,            1,  0, 1, 0, 0, 0, 0,            0, 0, WB, WB,  1, 0, 0};
    vecs[8]  = '{1, 6,     0, 0, 0,        0,            0,  1, 0, 1, 0, 1, 0,            0, 1, WB, 0,   1, 0, 1};
    vecs[9]  = '{0, 0,     0, 0, 0,        0,            0,  0, 0, 0, 0, 0, 0,            1, 0, WB, 0,   1, 1, 0};
    vecs[10] = '{0, 0,     1, 1, 32'h1000, 32'hDEADBEEF, 0,  0, 1, 0, 0, 0, 32'hDEADBEEF, 0, 0, WB, 0,   1, 0, 0};
    vecs[11] = '{0, 0,     1, 0, 0,        0,            0,  0, 1, 1, 0, 0, 0,            0, 0, WB, 0,   1, 0, 1};
    vecs[12] = '{0, 0,     0, 0, 0,        0,            0,  0, 0, 0, 0, 0, 0,            0, 1, WB, WA,  1, 0, 0};

    // Reset state, with a loader request held to show grants stay low
    drive(0, 0, 1, 0, 0, 0, 0);
    #12;
    chk("rst_load_gnt", {31'b0, bus.load_gnt}, 0);
    chk("rst_mem_en", {31'b0, bus.mem_en}, 0);
    chk("rst_run", {31'b0, bus.run}, 0);
    chk("rst_rvalid", {30'b0, bus.fetch_rvalid, bus.load_rvalid}, 0);
    chk("rst_rdata", bus.fetch_rdata | bus.load_rdata, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      drive(vecs[i].fr, vecs[i].fa, vecs[i].lr, vecs[i].lw, vecs[i].la, vecs[i].lwd, vecs[i].ld);
      #4;
      chk($sformatf("v%0d_fetch_gnt", i), {31'b0, bus.fetch_gnt}, {31'b0, vecs[i].e_fg});
      chk($sformatf("v%0d_load_gnt", i), {31'b0, bus.load_gnt}, {31'b0, vecs[i].e_lg});
      chk($sformatf("v%0d_mem_en", i), {31'b0, bus.mem_en}, {31'b0, vecs[i].e_en});
      chk($sformatf("v%0d_mem_we", i), {31'b0, bus.mem_we}, {31'b0, vecs[i].e_we});
      chk($sformatf("v%0d_mem_addr", i), {22'b0, bus.mem_addr}, {22'b0, vecs[i].e_addr});
      chk($sformatf("v%0d_mem_wdata", i), bus.mem_wdata, vecs[i].e_wd);
      chk($sformatf("v%0d_fetch_rvalid", i), {31'b0, bus.fetch_rvalid}, {31'b0, vecs[i].e_fv});
      chk($sformatf("v%0d_load_rvalid", i), {31'b0, bus.load_rvalid}, {31'b0, vecs[i].e_lv});
      chk($sformatf("v%0d_fetch_rdata", i), bus.fetch_rdata, vecs[i].e_frd);
      chk($sformatf("v%0d_load_rdata", i), bus.load_rdata, vecs[i].e_lrd);
      chk($sformatf("v%0d_run", i), {31'b0, bus.run}, {31'b0, vecs[i].e_run});
`ifdef IMEM_ARB_ERR_EN
      chk($sformatf("v%0d_fetch_err", i), {31'b0, bus.fetch_err}, {31'b0, vecs[i].e_ferr});
      chk($sformatf("v%0d_load_err", i), {31'b0, bus.load_err}, {31'b0, vecs[i].e_lerr});
`endif
    end

    // Both requesting in RUN: eight fetch grants then one forced loader slot
    for (int i = 0; i < 27; i++) begin
      @(negedge clk);
      if (i == 0) drive(1, 0, 1, 0, 4, 0, 0);
      #4;
      chk($sformatf("streak%0d_fetch_gnt", i), {31'b0, bus.fetch_gnt}, {31'b0, (i % 9) != 8});
      chk($sformatf("streak%0d_load_gnt", i), {31'b0, bus.load_gnt}, {31'b0, (i % 9) == 8});
    end

    // Reset right after a fetch grant: the pending response must vanish
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 0);
    #4;
    chk("rstmid_fetch_gnt", {31'b0, bus.fetch_gnt}, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rstmid_fetch_rvalid", {31'b0, bus.fetch_rvalid}, 0);
    chk("rstmid_fetch_rdata", bus.fetch_rdata, 0);
    chk("rstmid_run", {31'b0, bus.run}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #4;
      chk($sformatf("rstpost%0d_fetch_rvalid", i), {31'b0, bus.fetch_rvalid}, 0);
      chk($sformatf("rstpost%0d_run", i), {31'b0, bus.run}, 0);
    end

    // Back in BOOT: fetch is locked out while loader reads stream through
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(1, 4, 1, 0, 0, 0, 0);
      #4;
      chk($sformatf("boot%0d_fetch_gnt", i), {31'b0, bus.fetch_gnt}, 0);
      chk($sformatf("boot%0d_load_gnt", i), {31'b0, bus.load_gnt}, 1);
      if (i > 0) begin
        chk($sformatf("boot%0d_load_rvalid", i), {31'b0, bus.load_rvalid}, 1);
        chk($sformatf("boot%0d_load_rdata", i), bus.load_rdata, WA);
      end
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    #4;
    chk("boot_end_run", {31'b0, bus.run}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Shares the single-ported, word-addressed instruction memory between two requesters.
  - The core fetch path.
  - A boot/debug loader that writes program words and reads them back.
- Sequences a BOOT phase, in which only the loader is served, then a RUN phase, in which fetch has priority and a starvation guard protects the loader.
- Sits between the PC/fetch stage, the loader and the memory array. Read data is returned registered, one cycle after grant.

Parameters:
- ADDR_W, 32, byte-address width of both requesters.
- DATA_W, 32, instruction word width.
- DEPTH, 1024, memory depth in words; the word index is addr[ADDR_W-1:2].
- FETCH_STREAK_MAX, 8, maximum consecutive fetch grants while load_req is pending before the loader is forced one slot.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- fetch_req  in  1  fetch read request.
- fetch_addr  in  ADDR_W  fetch byte address.
- fetch_gnt  out  1  fetch accepted this cycle.
- fetch_rvalid  out  1  fetch read data valid; one-cycle pulse.
- fetch_rdata  out  DATA_W  fetch instruction word.
- load_req  in  1  loader request.
- load_we  in  1  1 = write, 0 = read.
- load_addr  in  ADDR_W  loader byte address.
- load_wdata  in  DATA_W  loader write data.
- load_done  in  1  pulse: program loaded, enter RUN.
- load_gnt  out  1  loader accepted this cycle.
- load_rvalid  out  1  loader read data valid; not asserted for writes.
- load_rdata  out  DATA_W  loader read word.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  $clog2(DEPTH)  word index.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory combinational read data.
- run  out  1  high in RUN state.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to BOOT; streak counter = 0.
  - All rvalid outputs = 0 and all rdata outputs = 0; run = 0.
  - Combinational outputs follow the state, so all grants and mem_en are 0 while in reset.
- Grants are combinational, in the same cycle as the request. At most one grant is asserted per cycle.
  - mem_* is driven from the granted requester.
  - With no grant, mem_en = 0, mem_we = 0, and mem_addr/mem_wdata = 0.
- Requester protocol: a requester holds req and its address/data stable until it sees gnt; req may be dropped the cycle after gnt.
- Read data: on a granted read, mem_rdata is registered at the next rising edge.
  - The owner's rvalid is high for exactly one cycle, with rdata valid in that cycle.
  - rdata holds its value afterwards.
- Back-to-back grants to the same or different requesters are allowed; throughput is one access per cycle.
- BOOT state:
  - fetch_gnt = 0; load_gnt = load_req.
  - load_done moves the state to RUN at the next edge.
  - A loader access in the same cycle as load_done still completes.
- RUN state:
  - fetch_req alone: fetch is granted.
  - load_req alone: loader is granted.
  - Both requesting: fetch is granted, unless streak == FETCH_STREAK_MAX, in which case the loader is granted.
  - The streak counter increments on each fetch grant made while load_req=1. It clears on any loader grant or when load_req=0, and saturates at FETCH_STREAK_MAX.
  - load_done is ignored in RUN. Only reset returns the block to BOOT.
- Out-of-range accesses (word index >= DEPTH):
  - The access is still granted and mem_en stays 0.
  - A write has no effect.
  - A read returns rdata = 0 with the normal rvalid pulse.
- Reset mid-operation: a pending rvalid is dropped and no response is produced after reset is released.

Optional Feature:
- Macro: IMEM_ARB_ERR_EN.
- When defined, adds output fetch_err (1) and output load_err (1).
  - Each pulses alongside its rvalid, or one cycle after a granted write for load_err.
  - The condition is addr[1:0] != 0 or an out-of-range address.
  - A misaligned access is still performed using the word index.
- When undefined, these ports are absent and misaligned addresses are silently truncated to a word index.

Decomposition:
- Package imem_pkg holds:
  - the state enum {BOOT, RUN};
  - the default constants for ADDR_W, DATA_W and DEPTH;
  - a function word_idx(addr) returning addr[ADDR_W-1:2].
- One sub-module, imem_resp_reg: the registered response stage (rvalid and rdata per owner, plus the optional err), instantiated once with an owner-select input.

Test Plan:
- Reset, then load writes 0x0064A423 to 0x0 and 0x00B62423 to 0x4, then load_done → run=1 next cycle, and fetch_req to 0x4 → fetch_rvalid one cycle later with fetch_rdata=0x00B62423.
- fetch_req=1 during BOOT for 10 cycles → fetch_gnt stays 0, and load reads are still served.
- RUN with fetch_req and load_req both held continuously, FETCH_STREAK_MAX=8 → 8 fetch grants, 1 load grant, repeating; never two grants in one cycle.
- Load read at byte address 0x1000 (index 1024) → load_rvalid pulse with rdata=0, mem_en=0; with IMEM_ARB_ERR_EN, load_err=1.
- Fetch to 0x6 (misaligned) → data from word 1 returned; fetch_err=1 only with IMEM_ARB_ERR_EN.
- Reset asserted the cycle after a fetch grant → no fetch_rvalid pulse, state returns to BOOT, run=0.
